// File: rtl/softmax_pkg.sv
// softmax writeback shared definitions
// defaults, state encoding and vector width
package softmax_pkg;
  localparam int DATAWIDTH  = 16;
  localparam int NUM        = 4;
  localparam int ADDRSIZE   = 8;
  localparam int FIFO_DEPTH = 4;
  localparam int VEC_W      = DATAWIDTH * NUM;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;
endpackage

// File: rtl/softmax_wb_fifo.sv
// vector FIFO between softmax output and RAM port
// head is read straight from the storage flops
module softmax_wb_fifo #(
  parameter int W     = 64,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     clr_n,
  input  logic                     push,
  input  logic [W-1:0]             din,
  input  logic                     pop,
  output logic [W-1:0]             dout,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty,
  output logic                     full
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wp;
  logic [AW-1:0] rp;
  logic          do_push;
  logic          do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rp];

  always_ff @(posedge clk) begin
    if (do_push) mem[wp] <= din;
  end

  always_ff @(posedge clk) begin
    if (!clr_n) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else begin
      if (do_push) wp <= wp + 1'b1;
      if (do_pop)  rp <= rp + 1'b1;
      unique case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end
endmodule

// File: rtl/softmax_writeback.sv
// softmax writeback: buffers result vectors and
// writes them to RAM at start_addr..end_addr
module softmax_writeback
  import softmax_pkg::*;
#(
  parameter int DATAWIDTH  = softmax_pkg::DATAWIDTH,
  parameter int NUM        = softmax_pkg::NUM,
  parameter int ADDRSIZE   = softmax_pkg::ADDRSIZE,
  parameter int FIFO_DEPTH = softmax_pkg::FIFO_DEPTH
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      init,
  input  logic                      start,
  input  logic [ADDRSIZE-1:0]       start_addr,
  input  logic [ADDRSIZE-1:0]       end_addr,
  input  logic [DATAWIDTH*NUM-1:0]  outp,
  input  logic                      outp_valid,
  output logic                      outp_ready,
  output logic [ADDRSIZE-1:0]       mem_addr,
  output logic [DATAWIDTH*NUM-1:0]  mem_d,
  output logic                      mem_we,
  input  logic                      mem_ready,
  output logic                      done,
  output logic                      err
);
  localparam int VW = DATAWIDTH * NUM;
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int TW = ADDRSIZE + 1;

  state_t              state, state_n;
  logic [ADDRSIZE-1:0] wr_addr, wr_addr_n;
  logic [TW-1:0]       total, total_n;
  logic [TW-1:0]       accepted, accepted_n;
  logic                done_n, err_n;

  logic          clr_n;
  logic          accept;
  logic          commit;
  logic [VW-1:0] head;
  logic [CW-1:0] count;
  logic          empty;
  logic          full;

  assign clr_n = reset && !init;

  // ready depends on registered state only
  assign outp_ready = (state == RUN) && !full &&
                      (accepted < total);
  assign accept = outp_valid && outp_ready;
  assign mem_we = ((state == RUN) || (state == DRAIN))
                  && !empty;
  assign commit   = mem_we && mem_ready;
  assign mem_addr = wr_addr;
  assign mem_d    = mem_we ? head : '0;

  softmax_wb_fifo #(
    .W     (VW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .clr_n (clr_n),
    .push  (accept),
    .din   (outp),
    .pop   (commit),
    .dout  (head),
    .count (count),
    .empty (empty),
    .full  (full)
  );

  always_comb begin
    state_n    = state;
    wr_addr_n  = wr_addr;
    total_n    = total;
    accepted_n = accepted;
    done_n     = done;
    err_n      = err;
    unique case (state)
      IDLE, DONE: begin
        if (start) begin
          wr_addr_n  = start_addr;
          accepted_n = '0;
          if (end_addr < start_addr) begin
            state_n = DONE;
            total_n = '0;
            done_n  = 1'b1;
            err_n   = 1'b1;
          end else begin
            state_n = RUN;
            total_n = ({1'b0, end_addr} -
                       {1'b0, start_addr}) + TW'(1);
            done_n  = 1'b0;
            err_n   = 1'b0;
          end
        end
      end
      RUN: begin
        if (accept) accepted_n = accepted + TW'(1);
        if (accepted_n == total) state_n = DRAIN;
        if (commit) wr_addr_n = wr_addr + 1'b1;
      end
      DRAIN: begin
        if (commit) begin
          wr_addr_n = wr_addr + 1'b1;
          if (count == CW'(1)) begin
            state_n = DONE;
            done_n  = 1'b1;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!clr_n) begin
      state    <= IDLE;
      wr_addr  <= '0;
      total    <= '0;
      accepted <= '0;
      done     <= 1'b0;
      err      <= 1'b0;
    end else begin
      state    <= state_n;
      wr_addr  <= wr_addr_n;
      total    <= total_n;
      accepted <= accepted_n;
      done     <= done_n;
      err      <= err_n;
    end
  end
endmodule

// File: tb/tb_softmax_writeback.sv
// directed bench for softmax_writeback
// commits are logged on the falling edge
module tb_softmax_writeback;
  logic        clk = 1'b0;
  logic        reset;
  logic        init;
  logic        start;
  logic [7:0]  start_addr;
  logic [7:0]  end_addr;
  logic [63:0] outp;
  logic        outp_valid;
  logic        outp_ready;
  logic [7:0]  mem_addr;
  logic [63:0] mem_d;
  logic        mem_we;
  logic        mem_ready;
  logic        done;
  logic        err;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int src_base, src_idx, src_n, acc_cnt;
  int first_acc, first_we, done_cyc, last_commit;
  logic [7:0]  wa[$];
  logic [63:0] wd[$];

  softmax_writeback dut (
    .clk        (clk),
    .reset      (reset),
    .init       (init),
    .start      (start),
    .start_addr (start_addr),
    .end_addr   (end_addr),
    .outp       (outp),
    .outp_valid (outp_valid),
    .outp_ready (outp_ready),
    .mem_addr   (mem_addr),
    .mem_d      (mem_d),
    .mem_we     (mem_we),
    .mem_ready  (mem_ready),
    .done       (done),
    .err        (err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (mem_we && mem_ready && reset && !init) begin
      wa.push_back(mem_addr);
      wd.push_back(mem_d);
      last_commit = cyc + 1;
    end
  end

  function automatic logic [63:0] mkvec(input int k);
    logic [15:0] b;
    b = 16'(k);
    return {b + 16'hA000, b + 16'hB100,
            b + 16'hC200, b + 16'hD300};
  endfunction

  task automatic step();
    bit acc;
    acc = (outp_valid === 1'b1) && (outp_ready === 1'b1);
    @(posedge clk);
    #1;
    cyc++;
    if (acc) begin
      acc_cnt++;
      src_idx++;
      if (first_acc < 0) first_acc = cyc;
    end
    outp_valid = (src_idx < src_n);
    outp = mkvec(src_base + src_idx);
    if (mem_we === 1'b1 && first_we < 0) first_we = cyc;
    if (done === 1'b1 && done_cyc < 0) done_cyc = cyc;
  endtask

  task automatic job_setup(input int base, input int n);
    wa.delete();
    wd.delete();
    src_base = base;
    src_idx = 0;
    src_n = n;
    acc_cnt = 0;
    first_acc = -1;
    first_we = -1;
    done_cyc = -1;
    last_commit = -1;
    outp_valid = (n > 0);
    outp = mkvec(base);
  endtask

  task automatic start_job(input logic [7:0] s,
                           input logic [7:0] e);
    start_addr = s;
    end_addr = e;
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget, output bit ok);
    int n;
    n = 0;
    while (done !== 1'b1 && n < budget) begin
      step();
      n++;
    end
    ok = (done === 1'b1);
    src_n = src_idx;
    outp_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    step();
    step();
    reset = 1'b1;
    step();
    checks++;
    if ({outp_ready, mem_we, done, err} !== 4'b0) begin
      failures++;
      $display("FAIL reset_flags got %b want 0000",
               {outp_ready, mem_we, done, err});
    end
    checks++;
    if (mem_addr !== 8'h00 || mem_d !== 64'h0) begin
      failures++;
      $display("FAIL reset_bus got %h/%h want 0/0",
               mem_addr, mem_d);
    end
    job_setup(0, 1);
    mem_ready = 1'b0;
    start_job(8'h10, 8'h13);
    step();
    step();
    init = 1'b1;
    step();
    init = 1'b0;
    checks++;
    if ({outp_ready, mem_we, done} !== 3'b0 ||
        mem_addr !== 8'h00 || mem_d !== 64'h0) begin
      failures++;
      $display("FAIL init_clear got %b %h %h want 0",
               {outp_ready, mem_we, done}, mem_addr, mem_d);
    end
  endtask

  task automatic test_basic();
    bit ok;
    int bad;
    job_setup(0, 4);
    mem_ready = 1'b1;
    start_job(8'h10, 8'h13);
    wait_done(40, ok);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL basic_done timeout done=%b want 1", done);
    end
    checks++;
    if (wa.size() != 4) begin
      failures++;
      $display("FAIL basic_count got %0d want 4", wa.size());
    end
    bad = 0;
    for (int i = 0; i < wa.size() && i < 4; i++)
      if (wa[i] !== 8'(8'h10 + i) || wd[i] !== mkvec(i))
        bad++;
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL basic_order got %0d bad writes want 0",
               bad);
    end
    checks++;
    if (first_we != first_acc || first_acc < 0) begin
      failures++;
      $display("FAIL basic_latency got we@%0d want acc@%0d",
               first_we, first_acc);
    end
    checks++;
    if (done_cyc != last_commit || err !== 1'b0) begin
      failures++;
      $display("FAIL basic_done_edge got %0d err=%b want %0d 0",
               done_cyc, err, last_commit);
    end
  endtask

  task automatic test_stall();
    bit ok;
    int bad;
    int moved;
    job_setup(20, 4);
    mem_ready = 1'b0;
    start_job(8'h10, 8'h13);
    moved = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (mem_we === 1'b1 &&
          (mem_addr !== 8'h10 || mem_d !== mkvec(20)))
        moved++;
    end
    checks++;
    if (acc_cnt != 4 || outp_ready !== 1'b0) begin
      failures++;
      $display("FAIL stall_fill got acc=%0d rdy=%b want 4 0",
               acc_cnt, outp_ready);
    end
    checks++;
    if (mem_we !== 1'b1 || moved != 0) begin
      failures++;
      $display("FAIL stall_hold got we=%b moved=%0d want 1 0",
               mem_we, moved);
    end
    checks++;
    if (wa.size() != 0) begin
      failures++;
      $display("FAIL stall_nowrite got %0d want 0", wa.size());
    end
    mem_ready = 1'b1;
    wait_done(40, ok);
    bad = (wa.size() == 4) ? 0 : 1;
    for (int i = 0; i < wa.size() && i < 4; i++)
      if (wa[i] !== 8'(8'h10 + i) || wd[i] !== mkvec(20 + i))
        bad++;
    checks++;
    if (!ok || bad != 0) begin
      failures++;
      $display("FAIL stall_release got ok=%b n=%0d bad=%0d want 1 4 0",
               ok, wa.size(), bad);
    end
  endtask

  task automatic test_single();
    bit ok;
    job_setup(40, 3);
    mem_ready = 1'b1;
    start_job(8'h05, 8'h05);
    for (int i = 0; i < 4; i++) step();
    checks++;
    if (acc_cnt != 1 || outp_ready !== 1'b0) begin
      failures++;
      $display("FAIL single_accept got %0d rdy=%b want 1 0",
               acc_cnt, outp_ready);
    end
    wait_done(20, ok);
    checks++;
    if (!ok || wa.size() != 1) begin
      failures++;
      $display("FAIL single_write got ok=%b n=%0d want 1 1",
               ok, wa.size());
    end else if (wa[0] !== 8'h05 || wd[0] !== mkvec(40)) begin
      failures++;
      $display("FAIL single_data got %h/%h want 05/%h",
               wa[0], wd[0], mkvec(40));
    end
  endtask

  task automatic test_err();
    bit we_seen;
    job_setup(50, 3);
    mem_ready = 1'b1;
    start_job(8'h20, 8'h1F);
    checks++;
    if ({err, done, outp_ready, mem_we} !== 4'b1100) begin
      failures++;
      $display("FAIL err_flags got %b want 1100",
               {err, done, outp_ready, mem_we});
    end
    we_seen = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      if (mem_we !== 1'b0 || outp_ready !== 1'b0)
        we_seen = 1'b1;
    end
    checks++;
    if (we_seen || wa.size() != 0 || acc_cnt != 0 ||
        err !== 1'b1) begin
      failures++;
      $display("FAIL err_quiet got act=%b n=%0d acc=%0d err=%b want 0 0 0 1",
               we_seen, wa.size(), acc_cnt, err);
    end
    src_n = 0;
    outp_valid = 1'b0;
  endtask

  task automatic test_mid_reset();
    bit ok;
    int n;
    job_setup(60, 2);
    mem_ready = 1'b0;
    start_job(8'h00, 8'h05);
    n = 0;
    while (acc_cnt < 2 && n < 10) begin
      step();
      n++;
    end
    step();
    checks++;
    if (acc_cnt != 2 || mem_we !== 1'b1) begin
      failures++;
      $display("FAIL midrst_pre got acc=%0d we=%b want 2 1",
               acc_cnt, mem_we);
    end
    reset = 1'b0;
    step();
    checks++;
    if ({outp_ready, mem_we, done, err} !== 4'b0 ||
        mem_addr !== 8'h00 || mem_d !== 64'h0) begin
      failures++;
      $display("FAIL midrst_clear got %b %h %h want 0",
               {outp_ready, mem_we, done, err}, mem_addr, mem_d);
    end
    reset = 1'b1;
    mem_ready = 1'b1;
    step();
    step();
    checks++;
    if (wa.size() != 0 || mem_we !== 1'b0) begin
      failures++;
      $display("FAIL midrst_flush got n=%0d we=%b want 0 0",
               wa.size(), mem_we);
    end
    job_setup(100, 2);
    start_job(8'h00, 8'h01);
    wait_done(30, ok);
    checks++;
    if (!ok || wa.size() != 2) begin
      failures++;
      $display("FAIL midrst_rerun got ok=%b n=%0d want 1 2",
               ok, wa.size());
    end else if (wa[0] !== 8'h00 || wa[1] !== 8'h01 ||
                 wd[0] !== mkvec(100) || wd[1] !== mkvec(101)) begin
      failures++;
      $display("FAIL midrst_data got %h %h %h %h want 00 01 %h %h",
               wa[0], wa[1], wd[0], wd[1],
               mkvec(100), mkvec(101));
    end
  endtask

  task automatic test_back_to_back();
    bit ok;
    job_setup(120, 2);
    mem_ready = 1'b1;
    start_job(8'hFE, 8'hFF);
    checks++;
    if (done !== 1'b0) begin
      failures++;
      $display("FAIL b2b_clear got done=%b want 0", done);
    end
    wait_done(30, ok);
    step();
    step();
    checks++;
    if (!ok || wa.size() != 2) begin
      failures++;
      $display("FAIL top_count got ok=%b n=%0d want 1 2",
               ok, wa.size());
    end else if (wa[0] !== 8'hFE || wa[1] !== 8'hFF ||
                 wd[1] !== mkvec(121)) begin
      failures++;
      $display("FAIL top_addr got %h %h %h want fe ff %h",
               wa[0], wa[1], wd[1], mkvec(121));
    end
    checks++;
    if (done !== 1'b1 || mem_we !== 1'b0) begin
      failures++;
      $display("FAIL top_hold got done=%b we=%b want 1 0",
               done, mem_we);
    end
  endtask

  initial begin
    reset = 1'b0;
    init = 1'b0;
    start = 1'b0;
    start_addr = '0;
    end_addr = '0;
    outp = '0;
    outp_valid = 1'b0;
    mem_ready = 1'b0;
    src_base = 0;
    src_idx = 0;
    src_n = 0;
    acc_cnt = 0;
    first_acc = -1;
    first_we = -1;
    done_cyc = -1;
    last_commit = -1;
    test_reset();
    test_basic();
    test_stall();
    test_single();
    test_err();
    test_mid_reset();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end
endmodule

// File: doc/softmax_writeback.md
Name: softmax_writeback

Overview:
- Downstream stage of softmax: consumes the NUM-lane result vectors streamed on outp.
- Buffers them in a small FIFO and writes them to the output on-chip RAM at consecutive addresses start_addr..end_addr.
- Signals done once the last vector is committed.
- Decouples softmax output timing from RAM write-port availability (mem_ready backpressure).

Parameters:
DATAWIDTH, 16, bits per lane
NUM, 4, lanes per vector (one RAM word = DATAWIDTH*NUM bits)
ADDRSIZE, 8, RAM address width
FIFO_DEPTH, 4, vector entries in internal FIFO (power of two, >=2)

Ports:
clk  in  1  clock, all logic on rising edge
reset  in  1  synchronous, active-low; reset==0 at a rising edge resets the block
init  in  1  synchronous soft clear, same effect as reset, active-high
start  in  1  one-cycle pulse, starts a job when IDLE
start_addr  in  ADDRSIZE  first write address, latched on start
end_addr  in  ADDRSIZE  last write address (inclusive), latched on start
outp  in  DATAWIDTH*NUM  result vector from softmax
outp_valid  in  1  outp holds a valid vector
outp_ready  out  1  block accepts outp this cycle
mem_addr  out  ADDRSIZE  RAM write address
mem_d  out  DATAWIDTH*NUM  RAM write data
mem_we  out  1  write request
mem_ready  in  1  RAM accepts the write this cycle
done  out  1  job complete, level
err  out  1  illegal range (end_addr < start_addr), level

Behaviour:
- Reset or init: state IDLE. All outputs are 0. FIFO is empty. Counters are 0.
- States: IDLE -> RUN on start. RUN -> DRAIN when all expected beats are accepted. DRAIN -> DONE when the last write commits. DONE -> RUN on a new start.
- Start is ignored in RUN and DRAIN.
- On start, latch the addresses. Set wr_addr=start_addr and total = end_addr-start_addr+1 (ADDRSIZE+1 bits). Clear done and err.
- If end_addr < start_addr: go directly to DONE with err=1 and done=1. No beats are accepted and no writes are issued.
- start_addr==end_addr gives total=1.
- Accept: a beat is taken when outp_valid && outp_ready.
  - outp_ready = (state==RUN) && fifo_count<FIFO_DEPTH && accepted<total.
  - outp_ready is computed from registered state only; there is no combinational path from mem_ready or outp_valid.
  - With a full FIFO, a pop in the same cycle does not raise ready.
- Write: mem_we = (state RUN or DRAIN) && FIFO non-empty. mem_d = FIFO head. mem_addr = wr_addr.
- A write commits when mem_we && mem_ready. On commit: pop the FIFO and increment wr_addr by 1.
- While mem_we=1 and mem_ready=0, mem_addr and mem_d are held stable.
- Latency: a beat accepted at edge N is presented on mem_d from cycle N+1. The FIFO output is registered; there is no bypass.
- Push and pop in the same cycle: fifo_count is unchanged and order is preserved.
- wr_addr never wraps inside a job. end_addr = 2^ADDRSIZE-1 is legal; the final increment result is unused.
- done: set in the cycle after the last commit, held until the next start, reset or init.
- Reset or init asserted mid-job: the job is aborted, the FIFO is flushed, and no further writes are issued.
- outp_valid while IDLE or DONE: ignored (ready=0). No error is raised.

Decomposition:
- Shared package softmax_pkg holds:
  - DATAWIDTH/NUM/ADDRSIZE defaults;
  - state encoding localparams (IDLE, RUN, DRAIN, DONE);
  - vector width constant VEC_W = DATAWIDTH*NUM.
- One sub-module: softmax_wb_fifo. It is a synchronous FIFO of VEC_W x FIFO_DEPTH with registered output, count, push/pop, and a synchronous active-low clear that is also driven by init.

Test Plan:
- start_addr=0x10, end_addr=0x13, 4 vectors valid back-to-back, mem_ready=1 -> writes at 0x10..0x13 in order, first mem_we one cycle after first accept; done=1 one cycle after the 0x13 commit; err=0.
- Same job with mem_ready=0 for 10 cycles -> FIFO fills to 4 and outp_ready=0. mem_addr=0x10 and mem_d stay stable while stalled. No vector is lost or duplicated after mem_ready=1.
- start_addr=0x05, end_addr=0x05, outp_valid held for 3 cycles -> exactly one accept; outp_ready falls after it; a single write at 0x05; done.
- start_addr=0x20, end_addr=0x1F -> err=1 and done=1 the cycle after start; mem_we never asserted; outp_ready stays 0.
- Drive reset=0 for one cycle after 2 of 6 beats -> all outputs 0, FIFO empty. A new start with 0x00..0x01 completes normally with no stale data written.
- end_addr=0xFF, start_addr=0xFE (ADDRSIZE=8) -> writes at 0xFE and 0xFF; done; no write to 0x00.
